// File: rtl/shiftreg_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shiftreg_ctrl : parallel-in/serial-out transmitter with simultaneous
//                 serial-in/parallel-out receiver and valid/ready handshakes.
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
module shiftreg_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_data,
  input  logic                  abort,
  output logic                  ser_out,
  output logic                  ser_en,
  input  logic                  ser_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int              CW     = $clog2(ADDR_WIDTH);
  localparam logic [CW-1:0]   c_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0]   c_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_tx;
  logic [ADDR_WIDTH-2:0]   r_rx;
  logic [ADDR_WIDTH-1:0]   r_out;
  logic [CW-1:0]           r_cnt;

  logic [ADDR_WIDTH-1:0]   w_tx_shift;
  logic [ADDR_WIDTH-1:0]   w_rx_shift;
  logic [ADDR_WIDTH-2:0]   w_rx_keep;
  logic                    w_tx_bit;
  logic                    w_load;
  logic                    w_shift;
  logic                    w_capture;

  // rx holds only the bits received so far; the final bit lands straight in out_data
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_tx_bit   = r_tx[ADDR_WIDTH-1];
      assign w_tx_shift = {r_tx[ADDR_WIDTH-2:0], 1'b0};
      assign w_rx_shift = {r_rx, ser_in};
      assign w_rx_keep  = w_rx_shift[ADDR_WIDTH-2:0];
    end else begin : g_lsb
      assign w_tx_bit   = r_tx[0];
      assign w_tx_shift = {1'b0, r_tx[ADDR_WIDTH-1:1]};
      assign w_rx_shift = {ser_in, r_rx};
      assign w_rx_keep  = w_rx_shift[ADDR_WIDTH-1:1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_capture = 1'b0;
    in_ready  = 1'b0;
    ser_en    = 1'b0;
    ser_out   = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy    = 1'b1;
        ser_en  = 1'b1;
        ser_out = w_tx_bit;
        // abort wins over the final-bit transition
        if (abort) begin
          w_next = S_IDLE;
        end else begin
          w_shift = 1'b1;
          if (r_cnt == c_LAST) begin
            w_capture = 1'b1;
            w_next    = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_load = 1'b1;
            w_next = S_SHIFT;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx  <= '0;
      r_rx  <= '0;
      r_cnt <= '0;
      r_out <= '0;
    end else begin
      if (w_load) begin
        r_tx  <= in_data;
        r_rx  <= '0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_tx  <= w_tx_shift;
        r_rx  <= w_rx_keep;
        r_cnt <= r_cnt + c_ONE;
      end
      if (w_capture) begin
        r_out <= w_rx_shift;
      end
    end
  end

  assign out_data = r_out;

endmodule
`default_nettype wire

// File: doc/shiftreg_ctrl.md
SHIFTREG_CTRL -- requirements
Module: shiftreg_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: width of the shift word, in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = shift the MSB first, 0 = shift the LSB first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a parallel word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the controller accepts a word.
REQ-007 SHALL have port in_data, input, ADDR_WIDTH bits: the parallel word to transmit.
REQ-008 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-009 SHALL have port ser_out, output, 1 bit: the serial transmit bit.
REQ-010 SHALL have port ser_en, output, 1 bit: high during every shift cycle.
REQ-011 SHALL have port ser_in, input, 1 bit: the serial receive bit, sampled while ser_en=1.
REQ-012 SHALL have port out_valid, output, 1 bit: a received word is available.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the received word.
REQ-014 SHALL have port out_data, output, ADDR_WIDTH bits: the received parallel word.
REQ-015 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT and DONE, with a bit counter of width clog2(ADDR_WIDTH).
REQ-017 SHALL drive in_ready=1 in IDLE, in_ready=0 in SHIFT, and in_ready=out_ready in DONE.
REQ-018 SHALL, in IDLE when in_valid&in_ready, load tx_reg<=in_data, clear rx_reg and the counter, and go to SHIFT.
REQ-019 SHALL, in SHIFT, drive ser_en=1 and ser_out=tx_reg[ADDR_WIDTH-1] when MSB_FIRST=1, else tx_reg[0].
REQ-020 SHALL, on each SHIFT edge, shift tx_reg one place toward the output end and increment the counter.
REQ-021 SHALL, on each SHIFT edge, shift ser_in into rx_reg: into rx[0], moving up, when MSB_FIRST=1; into rx[ADDR_WIDTH-1], moving down, when MSB_FIRST=0.
REQ-022 SHALL, on the edge at which the counter equals ADDR_WIDTH-1, go to DONE with out_data=rx_reg including the final bit.
REQ-023 SHALL keep a latency of exactly ADDR_WIDTH SHIFT cycles: accept at edge k -> ser_en high for cycles k+1..k+ADDR_WIDTH -> out_valid high after edge k+ADDR_WIDTH.
REQ-024 SHALL, in DONE, hold out_valid=1 and out_data stable until out_ready=1.
REQ-025 SHALL, in DONE, go to IDLE on out_ready&~in_valid.
REQ-026 SHALL, in DONE, load the new word and go directly to SHIFT on out_ready&in_valid (back-to-back, no IDLE cycle).
REQ-027 SHALL drive ser_out=0 and ser_en=0 outside SHIFT, and out_valid=0 outside DONE.
REQ-028 SHALL ignore in_valid in SHIFT; the offered word must be held by the source until in_ready=1.
REQ-029 SHALL, on abort=1 in SHIFT, go to IDLE at the next edge, assert no out_valid for that frame, and leave out_data unchanged.
REQ-030 SHALL ignore abort in IDLE and DONE.
REQ-031 SHALL, when abort=1 in SHIFT on the final-bit edge, give abort priority and go to IDLE.

Reset
REQ-032 SHALL, on rst_n=0, asynchronously force state=IDLE, counter=0, tx_reg=0, rx_reg=0 and out_data=0.
REQ-033 SHALL hold outputs at reset values while rst_n=0: ser_out=0, ser_en=0, out_valid=0, busy=0, in_ready=1.
REQ-034 SHALL, on reset mid-frame, discard the frame without output; the first edge after rst_n rises may accept a word.

Verification (ADDR_WIDTH=4)
REQ-035 SHALL cover loopback: ser_in tied to ser_out, MSB_FIRST=1, in_data=4'b1011 -> ser_out 1,0,1,1 with ser_en high 4 cycles -> out_valid with out_data=4'b1011.
REQ-036 SHALL cover independent receive: in_data=4'b1111, ser_in driven 0,1,1,0 -> ser_out 1,1,1,1 -> out_data=4'b0110.
REQ-037 SHALL cover backpressure: out_ready=0 for 3 cycles in DONE -> out_valid=1, out_data stable, in_ready=0; then out_ready=1 with in_valid=1 and in_data=4'b0101 -> ser_en=1 next cycle, ser_out=0, busy stays 1.
REQ-038 SHALL cover abort: abort=1 during the 2nd SHIFT cycle -> IDLE next cycle, ser_en=0, in_ready=1, out_valid never asserted.
REQ-039 SHALL cover reset mid-frame: rst_n=0 during SHIFT -> ser_en, busy and out_valid drop to 0 immediately; after release, in_data=4'b1100 completes a normal 4-cycle frame.
REQ-040 SHALL cover LSB-first: MSB_FIRST=0, loopback, in_data=4'b1011 -> ser_out 1,1,0,1 -> out_data=4'b1011.
